life_engine: RTL and testbench
==============================

# life_engine

Parametrised Game-of-Life generation engine that computes one generation in place over a WIDTH×HEIGHT bit-plane stored one row per word in an external single-port line memory. It replaces the hard-wired B3/S23, dead-border, fixed-size generation loop in the top-level control path. It adds a runtime rule (birth/survive masks), toroidal wrap mode, and per-generation population, stable and extinct reporting. It sits between the time-control trigger logic and the frame BRAM; the display path reads the BRAM only while `busy` is low.

## Interface
Parameters:
- `WIDTH`, default 64: cells per row; memory word width.
- `HEIGHT`, default 32: rows per frame, at least 3.
- `ADDR_W`, default 5: row address width; 2^ADDR_W ≥ HEIGHT.
- `POP_W`, default 16: population counter width; 2^POP_W > WIDTH×HEIGHT.

Ports:
- `clk_in`, in, 1: single clock. One clock; reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: compute one generation; sampled only in IDLE.
- `wrap`, in, 1: 1 = toroidal edges, 0 = dead border.
- `birth`, in, 9: bit n = dead cell with n live neighbours becomes alive.
- `survive`, in, 9: bit n = live cell with n live neighbours stays alive.
- `mem_addr`, out, ADDR_W: row address.
- `mem_rd_en`, out, 1: read strobe; data is valid on `mem_rdata` one cycle later.
- `mem_rdata`, in, WIDTH: read data.
- `mem_wr_en`, out, 1: write strobe; writes `mem_wdata` to `mem_addr` on the same edge.
- `mem_wdata`, out, WIDTH: write data.
- `busy`, out, 1: generation in progress.
- `done`, out, 1: one-cycle pulse at the end of a generation.
- `gen_count`, out, 32: completed generations; wraps at 2^32.
- `population`, out, POP_W: live cells in the last completed generation.
- `stable`, out, 1: the last generation changed no cell.
- `extinct`, out, 1: `population` == 0.

## Operation
- Reset: all outputs 0. FSM returns to IDLE. Row window and row-0 copy are cleared. The memory may hold a partially updated frame; this is accepted.
- IDLE, `start`=1: latch `wrap`, `birth`, `survive`. Set `busy`=1. Clear the population accumulator and the change flag. Go to PRIME.
- While busy, input changes have no effect, and `start` is ignored.
- PRIME (6 cycles): read row HEIGHT-1 into `above`; if `wrap`=0, load 0 instead. Read row 0 into `middle` and into the saved copy `row0`. Each read uses 3 cycles: RD (address and `rd_en`), LAT, LOAD (capture). Set r=0.
- Per row r, in order:
  - FETCH: for r<HEIGHT-1, read row r+1 into `below` (3 cycles). For r=HEIGHT-1, load `below` = `wrap` ? `row0` : 0 (1 cycle, no memory access).
  - CALC (1 cycle): for each column c:
    - n = 8-neighbour sum over above/middle/below, as a 4-bit value (0..8).
    - Column -1 and column WIDTH maps to WIDTH-1 and 0 when `wrap`=1, and read as 0 otherwise.
    - next[c] = middle[c] ? survive[n] : birth[n].
    - Register `next`. Add popcount(next) to the accumulator. OR (next≠middle) into the change flag.
  - WR (1 cycle): `mem_wr_en`=1, `mem_addr`=r, `mem_wdata`=`next`. Then shift above←middle and middle←below, increment r. If r was HEIGHT-1, go to DONE.
- In-place correctness: row r is written only after row r+1 has been read. The original row r-1 is held in `above`, and the original row 0 in `row0`.
- DONE (1 cycle):
  - `done`=1, `busy`=0, `gen_count`+1.
  - `population` ← accumulator. `stable` ← !change flag. `extinct` ← (accumulator==0).
  - Go to IDLE.
- `mem_rd_en` and `mem_wr_en` are never asserted together. Both are 0 outside RD and WR cycles.

## Timing
- `start` sampled at edge 0. PRIME starts at edge 1. `done`=1 for exactly the cycle after edge 5·HEIGHT+4.
  - The sum is 6 (PRIME) + 5·(HEIGHT-1) (rows 0..HEIGHT-2) + 3 (last row) + 1 (DONE).
- `start` held high across DONE starts the next generation on the first IDLE cycle, with no gap beyond one idle cycle.
- Status outputs update only at the DONE edge and hold until the next DONE or reset.
- The combinational CALC path is one adder tree per column. No multicycle paths.

## Test plan
- Blinker, 8×8, `wrap`=0, B3/S23 (`birth`=9'h008, `survive`=9'h00C), horizontal at row 3, cols 2-4:
  - After 1 generation: vertical at col 3, rows 2-4. `population`=3, `stable`=0.
  - After 2 generations: the original pattern is restored. `gen_count`=2.
- Block 2×2 at the corner, `wrap`=0 → memory unchanged, `stable`=1, `population`=4.
- Glider, 8×8, `wrap`=1 → after 32 generations the memory equals the initial frame, with at least one generation crossing both edges. Same glider with `wrap`=0 → it eventually becomes a 2×2 block; `stable`=1.
- Single cell, `birth`=9'h000, `survive`=9'h000 → memory is all zero, `extinct`=1, `population`=0.
- Timing, HEIGHT=32:
  - `done` pulse exactly 164 edges after `start`.
  - Second `start` pulses while busy are ignored; `gen_count`=1.
  - Memory-port monitor sees no simultaneous read and write, and sees row r written only after row r+1 is read.
- `rst_n` low mid-row 10 → all outputs 0 immediately (asynchronously). Then a fresh `start` completes normally with `gen_count`=1.

Source files
------------

// File: rtl/life_engine.sv
// life_engine: in-place Game-of-Life generation over a row-per-word line memory (rule/wrap in, single-port mem out, busy/done/gen_count/population/stable/extinct status)
module life_engine #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32,
  parameter int ADDR_W = 5,
  parameter int POP_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wrap,
  input  logic [8:0]        birth,
  input  logic [8:0]        survive,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       gen_count,
  output logic [POP_W-1:0]  population,
  output logic              stable,
  output logic              extinct
);
  typedef enum logic [3:0] {
    S_IDLE, S_A_RD, S_A_LAT, S_A_LD, S_M_RD, S_M_LAT, S_M_LD,
    S_B_RD, S_B_LAT, S_B_LD, S_B_LAST, S_CALC, S_WR, S_FIN
  } state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(HEIGHT - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] row;
  logic [WIDTH-1:0] above, middle, below, row0, next_q, next_c;
  logic [WIDTH+1:0] ae, me, be;
  logic [POP_W-1:0] acc, pop_c;
  logic [8:0] birth_q, survive_q;
  logic wrap_q, chg;
  assign ae = {wrap_q & above[0], above, wrap_q & above[WIDTH-1]};
  assign me = {wrap_q & middle[0], middle, wrap_q & middle[WIDTH-1]};
  assign be = {wrap_q & below[0], below, wrap_q & below[WIDTH-1]};
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    logic [3:0] n;
    assign n = 4'(ae[c]) + 4'(ae[c+1]) + 4'(ae[c+2]) + 4'(me[c]) + 4'(me[c+2])
             + 4'(be[c]) + 4'(be[c+1]) + 4'(be[c+2]);
    assign next_c[c] = me[c+1] ? survive_q[n] : birth_q[n];
  end
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < WIDTH; i++) pop_c = pop_c + POP_W'(next_c[i]);
  end
  assign busy = state_q != S_IDLE && state_q != S_FIN;
  assign done = state_q == S_FIN;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE:   state_d = start ? S_A_RD : S_IDLE;
      S_A_RD:   begin mem_addr = LAST; mem_rd_en = 1'b1; state_d = S_A_LAT; end
      S_A_LAT:  state_d = S_A_LD;
      S_A_LD:   state_d = S_M_RD;
      S_M_RD:   begin mem_rd_en = 1'b1; state_d = S_M_LAT; end
      S_M_LAT:  state_d = S_M_LD;
      S_M_LD:   state_d = S_B_RD;
      S_B_RD:   begin mem_addr = row + ADDR_W'(1); mem_rd_en = 1'b1; state_d = S_B_LAT; end
      S_B_LAT:  state_d = S_B_LD;
      S_B_LD:   state_d = S_CALC;
      S_B_LAST: state_d = S_CALC;
      S_CALC:   state_d = S_WR;
      S_WR: begin
        mem_addr  = row;
        mem_wr_en = 1'b1;
        mem_wdata = next_q;
        state_d   = row == LAST ? S_FIN : row == LAST - ADDR_W'(1) ? S_B_LAST : S_B_RD;
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      row        <= '0;
      above      <= '0;
      middle     <= '0;
      below      <= '0;
      row0       <= '0;
      next_q     <= '0;
      acc        <= '0;
      chg        <= 1'b0;
      wrap_q     <= 1'b0;
      birth_q    <= '0;
      survive_q  <= '0;
      gen_count  <= '0;
      population <= '0;
      stable     <= 1'b0;
      extinct    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        wrap_q    <= wrap;
        birth_q   <= birth;
        survive_q <= survive;
        acc       <= '0;
        chg       <= 1'b0;
      end
      if (state_q == S_A_LD) above <= wrap_q ? mem_rdata : '0;
      if (state_q == S_M_LD) begin
        middle <= mem_rdata;
        row0   <= mem_rdata;
        row    <= '0;
      end
      if (state_q == S_B_LD) below <= mem_rdata;
      if (state_q == S_B_LAST) below <= wrap_q ? row0 : '0;
      if (state_q == S_CALC) begin
        next_q <= next_c;
        acc    <= acc + pop_c;
        chg    <= chg | (next_c != middle);
      end
      if (state_q == S_WR) begin
        above  <= middle;
        middle <= below;
        row    <= row + ADDR_W'(1);
        if (row == LAST) begin
          gen_count  <= gen_count + 32'd1;
          population <= acc;
          stable     <= !chg;
          extinct    <= acc == '0;
        end
      end
    end
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed self-checking bench for life_engine with a cell-level reference model
module tb_life_engine;
  localparam int W = 8, H = 8, AW = 3, PW = 8, LAT = 5 * H + 4, LIMIT = 400;
  localparam logic [W*H-1:0] BLINK = {8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00};
  localparam logic [W*H-1:0] VERT  = {8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
  localparam logic [W*H-1:0] BLOCK = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h03};
  localparam logic [W*H-1:0] CELL  = {8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [W*H-1:0] GLIDE = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h04, 8'h02};
  logic clk_in = 1'b0, rst_n = 1'b0, start = 1'b0, wrap = 1'b0;
  logic [8:0] birth = '0, survive = '0;
  logic [AW-1:0] mem_addr;
  logic mem_rd_en, mem_wr_en, busy, done, stable, extinct;
  logic [W-1:0] mem_rdata = '0, mem_wdata;
  logic [31:0] gen_count;
  logic [PW-1:0] population;
  logic [W-1:0] mem [H];
  logic [W-1:0] exp_frame [H];
  bit rd_seen [H];
  int exp_pop, last_pop, n_cmp = 0, n_bad = 0;
  int unsigned exp_gen = 0;
  bit exp_stable, exp_valid = 0, prev_done = 0, last_stable, last_extinct;
  life_engine #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .POP_W(PW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .wrap(wrap), .birth(birth), .survive(survive),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .gen_count(gen_count),
    .population(population), .stable(stable), .extinct(extinct)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_step();
    int n, rr, cc, pop;
    bit alive, nb, same;
    pop = 0;
    same = 1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
            n += int'(mem[rr][cc]);
          end
        alive = mem[r][c];
        nb = alive ? survive[n] : birth[n];
        exp_frame[r][c] = nb;
        pop += int'(nb);
        if (nb != alive) same = 0;
      end
    exp_pop = pop;
    exp_stable = same;
    exp_valid = 1;
    exp_gen++;
    for (int r = 0; r < H; r++) rd_seen[r] = 0;
  endtask
  always @(negedge clk_in) if (rst_n) begin
    if (mem_rd_en || mem_wr_en) check("rd_wr_exclusive", mem_rd_en & mem_wr_en, 0);
    if (mem_wr_en && exp_valid) begin
      check("wdata", mem_wdata, exp_frame[mem_addr]);
      if (int'(mem_addr) < H - 1) check("read_before_write", rd_seen[int'(mem_addr) + 1], 1);
    end
    if (mem_rd_en) rd_seen[mem_addr] = 1;
    if (done) begin
      check("done_width", prev_done, 0);
      check("busy_at_done", busy, 0);
      check("gen_count", gen_count, exp_gen);
      check("population", population, exp_pop);
      check("stable", stable, exp_stable);
      check("extinct", extinct, exp_pop == 0);
      for (int r = 0; r < H; r++) check("frame", mem[r], exp_frame[r]);
      last_pop = population;
      last_stable = stable;
      last_extinct = extinct;
    end
    prev_done = done;
  end
  task automatic load(input logic [W*H-1:0] f);
    @(negedge clk_in);
    for (int r = 0; r < H; r++) mem[r] <= f[r*W +: W];
  endtask
  task automatic check_frame(input string name, input logic [W*H-1:0] f);
    for (int r = 0; r < H; r++) check(name, mem[r], f[r*W +: W]);
  endtask
  task automatic chk_zero(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_gen"}, gen_count, 0);
    check({name, "_pop"}, population, 0);
    check({name, "_stable"}, stable, 0);
    check({name, "_extinct"}, extinct, 0);
    check({name, "_rd"}, mem_rd_en, 0);
    check({name, "_wr"}, mem_wr_en, 0);
    check({name, "_addr"}, mem_addr, 0);
    check({name, "_wdata"}, mem_wdata, 0);
  endtask
  task automatic gen(input bit hold, input bit poke);
    int lat;
    logic sw;
    logic [8:0] sb, ss;
    sw = wrap;
    sb = birth;
    ss = survive;
    @(negedge clk_in);
    start = 1'b1;
    model_step();
    @(posedge clk_in);
    #1;
    if (!hold) start = 1'b0;
    lat = 0;
    while (!done && lat < LIMIT) begin
      @(posedge clk_in);
      #1;
      lat++;
      if (poke && lat == 10) begin
        start = 1'b1;
        wrap = ~wrap;
        birth = 9'h1FF;
        survive = 9'h000;
      end
      if (poke && lat == 12) begin
        start = 1'b0;
        wrap = sw;
        birth = sb;
        survive = ss;
      end
    end
    check("latency", lat, LAT);
    @(negedge clk_in);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    chk_zero("reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    wrap = 1'b0;
    birth = 9'h008;
    survive = 9'h00C;
    load(BLINK);
    gen(0, 0);
    check_frame("blinker_gen1", VERT);
    check("blinker_gen1_pop", last_pop, 3);
    check("blinker_gen1_stable", last_stable, 0);
    gen(0, 0);
    check_frame("blinker_gen2", BLINK);
    check("blinker_gen2_count", gen_count, 2);
    load(BLOCK);
    gen(0, 0);
    check_frame("block", BLOCK);
    check("block_stable", last_stable, 1);
    check("block_pop", last_pop, 4);
    birth = 9'h000;
    survive = 9'h000;
    load(CELL);
    gen(0, 0);
    check_frame("cell", '0);
    check("cell_extinct", last_extinct, 1);
    check("cell_pop", last_pop, 0);
    birth = 9'h008;
    survive = 9'h00C;
    load(BLINK);
    gen(0, 1);
    check_frame("ignored_inputs", VERT);
    repeat (3) @(negedge clk_in);
    check("ignored_start_busy", busy, 0);
    check("ignored_start_count", gen_count, 5);
    wrap = 1'b1;
    load(GLIDE);
    for (int g = 0; g < 31; g++) gen(1, 0);
    gen(0, 0);
    check_frame("glider_torus32", GLIDE);
    check("glider_torus_count", gen_count, 37);
    wrap = 1'b0;
    load(GLIDE);
    for (int g = 0; g < 40; g++) begin
      gen(0, 0);
      if (last_stable) break;
    end
    check("glider_border_stable", last_stable, 1);
    check("glider_border_pop", last_pop, 4);
    load(BLINK);
    @(negedge clk_in);
    start = 1'b1;
    model_step();
    @(posedge clk_in);
    #1;
    start = 1'b0;
    repeat (6 + 5 * 5 + 2) @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    exp_valid = 0;
    #1;
    chk_zero("async_reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    exp_gen = 0;
    gen(0, 0);
    check("restart_count", gen_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
